// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes and loader instruction classes.
// The main decoder and the program loader both import this package.
package mips_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        CLS_LW    = 3'd0,
        CLS_SW    = 3'd1,
        CLS_RTYPE = 3'd2,
        CLS_ADDI  = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_J     = 3'd5
    } instrClass_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: instruction class plus fields to a 32-bit MIPS word.
// Classes 6 and 7 produce a zero word with legal deasserted.
module instr_field_packer
    import mips_pkg::*;
(
    input  logic [2:0]  instrClass,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (instrClass)
            CLS_LW:    word = {OP_LW, rs, rt, imm};
            CLS_SW:    word = {OP_SW, rs, rt, imm};
            CLS_ADDI:  word = {OP_ADDI, rs, rt, imm};
            CLS_BEQ:   word = {OP_BEQ, rs, rt, imm};
            CLS_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            CLS_J:     word = {OP_J, target};
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts instruction fields over valid/ready, packs them and
// writes the words to sequential instruction-memory addresses.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [2:0]            In_Class,
    input  logic [4:0]            In_Rs,
    input  logic [4:0]            In_Rt,
    input  logic [4:0]            In_Rd,
    input  logic [4:0]            In_Shamt,
    input  logic [5:0]            In_Funct,
    input  logic [15:0]           In_Imm,
    input  logic [25:0]           In_Target,
    input  logic                  In_Last,
    output logic                  Mem_WrEn,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic [31:0]           Mem_WrData,
    input  logic                  Mem_Ready,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err,
    output logic [ADDR_WIDTH:0]   Count
);

    typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_t;

    state_t                stateQ, stateD;
    logic [ADDR_WIDTH-1:0] ptrQ, ptrD;
    logic [ADDR_WIDTH:0]   countQ, countD;
    logic                  errQ, errD;
    logic                  lastQ, lastD;
    logic [31:0]           wordQ, wordD;

    logic [31:0] packedWord;
    logic        packedLegal;

    instr_field_packer u_packer (
        .instrClass (In_Class),
        .rs         (In_Rs),
        .rt         (In_Rt),
        .rd         (In_Rd),
        .shamt      (In_Shamt),
        .funct      (In_Funct),
        .imm        (In_Imm),
        .target     (In_Target),
        .word       (packedWord),
        .legal      (packedLegal)
    );

    always_comb begin
        stateD = stateQ;
        ptrD   = ptrQ;
        countD = countQ;
        errD   = errQ;
        lastD  = lastQ;
        wordD  = wordQ;
        case (stateQ)
            StIdle, StDone: begin
                if (Start) begin
                    stateD = StAccept;
                    ptrD   = BASE_ADDR;
                    countD = '0;
                    errD   = 1'b0;
                end
            end
            StAccept: begin
                if (In_Valid) begin
                    wordD = packedWord;
                    lastD = In_Last;
                    if (packedLegal) begin
                        stateD = StWrite;
                    end else begin
                        errD   = 1'b1;
                        stateD = In_Last ? StDone : StAccept;
                    end
                end
            end
            StWrite: begin
                if (Mem_Ready) begin
                    countD = countQ + 1'b1;
                    // Top address ends the session; the pointer is held, never wrapped.
                    if (&ptrQ) begin
                        stateD = StDone;
                        if (!lastQ) begin
                            errD = 1'b1;
                        end
                    end else begin
                        ptrD   = ptrQ + 1'b1;
                        stateD = lastQ ? StDone : StAccept;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateQ <= StIdle;
            ptrQ   <= BASE_ADDR;
            countQ <= '0;
            errQ   <= 1'b0;
            lastQ  <= 1'b0;
            wordQ  <= '0;
        end else begin
            stateQ <= stateD;
            ptrQ   <= ptrD;
            countQ <= countD;
            errQ   <= errD;
            lastQ  <= lastD;
            wordQ  <= wordD;
        end
    end

    // Gating with RST abandons a pending write in the reset cycle itself.
    assign Mem_WrEn   = (stateQ == StWrite) && !RST;
    assign In_Ready   = (stateQ == StAccept);
    assign Busy       = (stateQ == StAccept) || (stateQ == StWrite);
    assign Done       = (stateQ == StDone);
    assign Err        = errQ;
    assign Count      = countQ;
    assign Mem_Addr   = ptrQ;
    assign Mem_WrData = wordQ;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes expected writes, a monitor
// pops and compares each accepted memory write.
module tb_instr_encoder;

    localparam int AW = 8;
    localparam int TOP = (1 << AW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Start = 1'b0;
    logic          In_Valid = 1'b0;
    logic          In_Ready;
    logic [2:0]    In_Class = '0;
    logic [4:0]    In_Rs = '0, In_Rt = '0, In_Rd = '0, In_Shamt = '0;
    logic [5:0]    In_Funct = '0;
    logic [15:0]   In_Imm = '0;
    logic [25:0]   In_Target = '0;
    logic          In_Last = 1'b0;
    logic          Mem_WrEn;
    logic [AW-1:0] Mem_Addr;
    logic [31:0]   Mem_WrData;
    logic          Mem_Ready = 1'b1;
    logic          Busy, Done, Err;
    logic [AW:0]   Count;

    instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Class(In_Class), .In_Rs(In_Rs), .In_Rt(In_Rt), .In_Rd(In_Rd),
        .In_Shamt(In_Shamt), .In_Funct(In_Funct), .In_Imm(In_Imm), .In_Target(In_Target),
        .In_Last(In_Last), .Mem_WrEn(Mem_WrEn), .Mem_Addr(Mem_Addr), .Mem_WrData(Mem_WrData),
        .Mem_Ready(Mem_Ready), .Busy(Busy), .Done(Done), .Err(Err), .Count(Count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t expQ[$];
    int  errors = 0;
    int  checks = 0;
    bit  randReady = 1'b0;

    // Session model state
    int  mAddr, mCount;
    bit  mErr, mDone;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder from the opcode table, built by weighted field sums.
    function automatic logic [32:0] refEncode(input int cls, input int rs, input int rt,
            input int rd, input int sh, input int fn, input int imm, input int tgt);
        longint unsigned op, w;
        case (cls)
            0: op = 35;
            1: op = 43;
            2: op = 0;
            3: op = 8;
            4: op = 4;
            5: op = 2;
            default: return 33'd0;
        endcase
        if (cls == 5) w = op * 64'd67108864 + longint'(tgt);
        else if (cls == 2)
            w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048
                + sh * 64'd64 + longint'(fn);
        else w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + longint'(imm);
        return {1'b1, w[31:0]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic startSession();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        mAddr = 0; mCount = 0; mErr = 0; mDone = 0;
    endtask

    task automatic sendInstr(input logic [2:0] cls, input logic [4:0] rs, input logic [4:0] rt,
            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
            input logic [15:0] imm, input logic [25:0] tgt, input bit last,
            input bit useLit, input logic [31:0] lit);
        logic [32:0] r;
        bit acc = 0;
        int n = 0;
        wr_t e;
        In_Class = cls; In_Rs = rs; In_Rt = rt; In_Rd = rd; In_Shamt = sh;
        In_Funct = fn; In_Imm = imm; In_Target = tgt; In_Last = last; In_Valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge CLK);
            if (In_Ready) acc = 1;
            tick();
            n++;
        end
        In_Valid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 64'd0, 64'd1);
            return;
        end
        r = refEncode(int'(cls), int'(rs), int'(rt), int'(rd), int'(sh), int'(fn),
                      int'(imm), int'(tgt));
        if (r[32]) begin
            e.addr = mAddr[AW-1:0];
            e.data = useLit ? lit : r[31:0];
            expQ.push_back(e);
            mCount++;
            if (mAddr == TOP) begin
                mDone = 1;
                if (!last) mErr = 1;
            end else begin
                mAddr++;
                if (last) mDone = 1;
            end
        end else begin
            mErr = 1;
            if (last) mDone = 1;
        end
    endtask

    task automatic waitDoneAndCheck(input string tag);
        int n = 0;
        @(negedge CLK);
        while (!Done && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_done"}, 64'(Done), 64'd1);
        check({tag, "_count"}, 64'(Count), 64'(mCount));
        check({tag, "_err"}, 64'(Err), 64'(mErr));
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_pending"}, 64'(expQ.size()), 64'd0);
        tick();
    endtask

    // Monitor: compares accepted writes and checks stall stability.
    logic          prevStall = 1'b0;
    logic [AW-1:0] prevAddr;
    logic [31:0]   prevData;
    logic [AW:0]   prevCount;

    always @(negedge CLK) begin
        wr_t e;
        if (!RST && prevStall) begin
            check("stall_wren", 64'(Mem_WrEn), 64'd1);
            check("stall_addr", 64'(Mem_Addr), 64'(prevAddr));
            check("stall_data", 64'(Mem_WrData), 64'(prevData));
            check("stall_count", 64'(Count), 64'(prevCount));
        end
        if (Mem_WrEn) check("ready_during_write", 64'(In_Ready), 64'd0);
        if (Mem_WrEn && Mem_Ready) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", 64'(Mem_Addr), 64'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                check("wr_addr", 64'(Mem_Addr), 64'(e.addr));
                check("wr_data", 64'(Mem_WrData), 64'(e.data));
            end
        end
        prevStall = Mem_WrEn && !Mem_Ready && !RST;
        prevAddr  = Mem_Addr;
        prevData  = Mem_WrData;
        prevCount = Count;
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (randReady) Mem_Ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_in_ready", 64'(In_Ready), 64'd0);
        check("rst_wren", 64'(Mem_WrEn), 64'd0);
        check("rst_addr", 64'(Mem_Addr), 64'd0);
        check("rst_data", 64'(Mem_WrData), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_err", 64'(Err), 64'd0);
        check("rst_count", 64'(Count), 64'd0);
        tick();

        // LW single instruction
        startSession();
        sendInstr(3'd0, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1, 1, 32'h8C430004);
        waitDoneAndCheck("lw");

        // RTYPE then J, with a Start pulse mid-session that must be ignored
        startSession();
        sendInstr(3'd2, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'd0, 0, 1, 32'h00221820);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        sendInstr(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000010, 1, 1, 32'h08000010);
        waitDoneAndCheck("rtype_j");

        // BEQ with memory stalled for three cycles
        startSession();
        Mem_Ready = 1'b0;
        sendInstr(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1, 1, 32'h1085FFFF);
        @(negedge CLK);
        check("beq_latency_wren", 64'(Mem_WrEn), 64'd1);
        check("beq_in_ready", 64'(In_Ready), 64'd0);
        tick();
        tick();
        tick();
        Mem_Ready = 1'b1;
        waitDoneAndCheck("beq");

        // Illegal class then ADDI
        startSession();
        sendInstr(3'd6, 5'd7, 5'd7, 5'd7, 5'd7, 6'd7, 16'h7777, 26'd7, 0, 0, 32'd0);
        sendInstr(3'd3, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1, 1, 32'h20010005);
        waitDoneAndCheck("illegal_addi");

        // Randomized sessions against the reference model
        randReady = 1'b1;
        for (int s = 0; s < 20; s++) begin
            int len = $urandom_range(1, 8);
            startSession();
            for (int i = 0; i < len; i++) begin
                sendInstr(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                          5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom),
                          (i == len - 1), 0, 32'd0);
            end
            waitDoneAndCheck("random");
        end

        // Overflow: fill every address without Last
        startSession();
        for (int i = 0; i <= TOP; i++) begin
            sendInstr(3'($urandom_range(0, 5)), 5'($urandom), 5'($urandom), 5'($urandom),
                      5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom), 0, 0, 32'd0);
        end
        waitDoneAndCheck("overflow");
        In_Class = 3'd0;
        In_Last = 1'b0;
        In_Valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("overflow_no_accept", 64'(In_Ready), 64'd0);
            tick();
        end
        In_Valid = 1'b0;
        check("overflow_count_hold", 64'(Count), 64'(TOP + 1));

        // Reset while a write is pending
        randReady = 1'b0;
        Mem_Ready = 1'b0;
        startSession();
        sendInstr(3'd1, 5'd9, 5'd10, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1, 1, 32'hAD2A1234);
        n = 0;
        @(negedge CLK);
        while (!Mem_WrEn && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("rstmid_in_write", 64'(Mem_WrEn), 64'd1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        expQ.delete();
        @(negedge CLK);
        check("rstmid_wren", 64'(Mem_WrEn), 64'd0);
        check("rstmid_busy", 64'(Busy), 64'd0);
        check("rstmid_count", 64'(Count), 64'd0);
        check("rstmid_addr", 64'(Mem_Addr), 64'd0);
        tick();
        Mem_Ready = 1'b1;
        startSession();
        sendInstr(3'd0, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1, 1, 32'h8C430004);
        waitDoneAndCheck("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program loader that builds MIPS instruction words and writes them into instruction memory. It is the producer-side counterpart of the control unit's main decoder: it emits the opcodes the decoder consumes. The block takes instruction class and fields over a valid/ready handshake, packs a 32-bit word, and writes it to sequential word addresses through a stallable memory write port. It sits between the test or boot host and the instruction memory.

## Interface
- ADDR_WIDTH, 8, word-address width; memory depth is 2^ADDR_WIDTH words
- BASE_ADDR, 0, first word address written after Start
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- Start  in  1  one-cycle pulse; begins a load session
- In_Valid  in  1  instruction fields valid
- In_Ready  out  1  block accepts fields this cycle
- In_Class  in  3  0 LW, 1 SW, 2 RTYPE, 3 ADDI, 4 BEQ, 5 J, 6–7 illegal
- In_Rs, In_Rt, In_Rd, In_Shamt  in  5 each  register/shift fields
- In_Funct  in  6  R-type function field
- In_Imm  in  16  immediate / branch offset
- In_Target  in  26  jump target
- In_Last  in  1  marks final instruction of session
- Mem_WrEn  out  1  write request
- Mem_Addr  out  ADDR_WIDTH  word address
- Mem_WrData  out  32  encoded instruction
- Mem_Ready  in  1  memory accepts write when Mem_WrEn && Mem_Ready
- Busy  out  1  state is ACCEPT or WRITE
- Done  out  1  session finished, level until next Start
- Err  out  1  sticky: illegal class or overflow this session
- Count  out  ADDR_WIDTH+1  words written this session

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE/DONE + Start → ACCEPT; pointer ← BASE_ADDR, Count ← 0, Err ← 0, Done ← 0. Start is ignored in ACCEPT/WRITE.
- ACCEPT: In_Ready=1. On In_Valid, fields are registered. A legal class goes to WRITE. An illegal class sets Err, writes nothing, and goes to ACCEPT, or to DONE if In_Last.
- WRITE: Mem_WrEn=1, with Mem_Addr and Mem_WrData held stable until Mem_Ready. On acceptance, pointer+1 and Count+1. Next state is DONE if the registered Last is set, or if the pointer was 2^ADDR_WIDTH−1. Otherwise next state is ACCEPT.
- Overflow: if the last address is written without Last, the block enters DONE and sets Err. The pointer does not wrap into a live session.
- Encoding, opcode at [31:26]:
  - LW 100011, SW 101011, ADDI 001000, BEQ 000100: {op, rs, rt, imm}
  - RTYPE 000000: {op, rs, rt, rd, shamt, funct}
  - J 000010: {op, target}
- Unused input fields are ignored.

## Timing
- Reset values: In_Ready=0, Mem_WrEn=0, Mem_Addr=BASE_ADDR, Mem_WrData=0, Busy=0, Done=0, Err=0, Count=0. State = IDLE.
- In_Ready is a registered state decode; it does not depend combinationally on In_Valid.
- Latency: fields accepted at edge N → Mem_WrEn high in cycle N+1. Peak throughput is one instruction per 2 cycles.
- Mem_Ready low holds WRITE indefinitely. In_Ready stays 0 and Count is unchanged.
- Done and Count update on the edge that completes the final write.
- RST mid-session (any state): the block returns to IDLE next cycle and Mem_WrEn drops immediately. A partially presented write is abandoned.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J
  - instruction-class encoding
  - the main decoder uses the same opcode constants
- The FSM state enum is local to the block.
- One combinational sub-module, instr_field_packer, maps class + fields → {32-bit word, legal flag}. The FSM, pointer and counter live in instr_encoder.

## Test plan
- Start; LW rs=2 rt=3 imm=0x0004, Last=1, Mem_Ready=1 → Mem_WrData=0x8C430004 @ addr 0; Count=1, Done=1, Err=0.
- RTYPE rs=1 rt=2 rd=3 shamt=0 funct=0x20, then J target=0x0000010 (Last) → 0x00221820 @0, 0x08000010 @1, Count=2.
- BEQ rs=4 rt=5 imm=0xFFFF with Mem_Ready low 3 cycles → Mem_WrEn, Addr and Data=0x1085FFFF stable for 4 cycles; In_Ready=0; single write.
- Illegal class 6, then ADDI rs=0 rt=1 imm=0x0005 (Last) → no write for class 6; Err=1; 0x20010005 @ addr 0; Count=1.
- ADDR_WIDTH=2, five instructions without Last → writes @0–3, DONE after 4th, Err=1, Count=4, fifth never accepted.
- RST asserted in WRITE → next cycle Mem_WrEn=0, Busy=0, Count=0; Start then resumes from BASE_ADDR.
